// File: rtl/input_port_rx.sv
// Serial input device: 8N1 receiver feeding a small FIFO whose head byte is INPR, with FGI as the input flag.
// Latency: a byte appears on INPR/FGI one cycle after its stop-bit sample, ~155 clk after the start edge at the pin.
// Backpressure: none toward the line; a byte arriving while full (and not popped that cycle) is dropped and sets overrun.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   rx_serial            asynchronous serial line, idles high
//   inp_ack              one-cycle pop strobe from the CPU's INP instruction
//   err_clr              clears the sticky overrun / frame_err flags
//   INPR                 registered FIFO head byte, 0 when empty
//   FGI                  registered "FIFO non-empty" flag
//   overrun, frame_err   sticky error flags
module input_port_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_serial,
  input  logic              inp_ack,
  input  logic              err_clr,
  output logic [DATA_W-1:0] INPR,
  output logic              FGI,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT   = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start edge.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM. The start bit is re-checked at its midpoint; from there every
  // later sample lands one full bit period on, i.e. near each bit's centre.
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line that has gone high again by mid-start-bit was a glitch.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_W-1:1]};  // LSB arrives first
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stop-bit sample cycle: the completed byte is pushed or flagged right here.
  logic stop_sample;
  logic push_req;
  logic ferr_set;

  assign stop_sample = (state == STOP) && (cnt == BIT_LAST);
  assign push_req    = stop_sample && rx_s;
  assign ferr_set    = stop_sample && !rx_s;

  // ---------------------------------------------------------------------------
  // FIFO with a registered head (INPR). A pop frees a slot in the same cycle,
  // so a push that coincides with a pop is accepted even when full.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_next;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    count_nxt;
  logic [DATA_W-1:0] head_nxt;
  logic              pop;
  logic              push_ok;
  logic              overflow;

  assign pop      = inp_ack && (count != '0);
  assign push_ok  = push_req && ((count != FULL_CNT) || pop);
  assign overflow = push_req && (count == FULL_CNT) && !pop;
  assign rd_next  = rd_ptr + 1'b1;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // The head only moves on a pop, or when a byte lands in an empty FIFO.
  // When the popped entry was the last one, a simultaneous push becomes the
  // new head directly since it is not yet readable from mem.
  always_comb begin
    head_nxt = INPR;
    if (pop) begin
      if (count > ONE_CNT) begin
        head_nxt = mem[rd_next];
      end else if (push_ok) begin
        head_nxt = shreg;
      end else begin
        head_nxt = '0;
      end
    end else if (push_ok && (count == '0)) begin
      head_nxt = shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      INPR      <= '0;
      FGI       <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      count     <= count_nxt;
      INPR      <= head_nxt;
      FGI       <= (count_nxt != '0);
      // A new error in the same cycle as err_clr wins.
      overrun   <= overflow | (overrun & ~err_clr);
      frame_err <= ferr_set | (frame_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_input_port_rx.sv
// Bench for input_port_rx: table-driven vectors, hand-written timing corners,
// then random operations checked against a queue-based model.
module tb_input_port_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_serial;
  logic       inp_ack;
  logic       err_clr;
  logic [7:0] INPR;
  logic       FGI;
  logic       overrun;
  logic       frame_err;

  always #5 clk = ~clk;

  input_port_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .DATA_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_serial(rx_serial),
    .inp_ack  (inp_ack),
    .err_clr  (err_clr),
    .INPR     (INPR),
    .FGI      (FGI),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  int vec_cnt = 0;
  int mis_cnt = 0;

  typedef enum logic [1:0] {OP_FRAME, OP_ACK, OP_CLR, OP_GLITCH} op_e;

  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic       stop;
    logic       exp_fgi;
    logic [7:0] exp_inpr;
    logic       exp_ovr;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  logic [7:0] mq[$];
  logic       m_ovr;
  logic       m_ferr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic efgi, input logic [7:0] einpr,
                             input logic eovr, input logic eferr);
    check_b({name, ".FGI"}, FGI, efgi);
    check_v({name, ".INPR"}, INPR, einpr);
    check_b({name, ".overrun"}, overrun, eovr);
    check_b({name, ".frame_err"}, frame_err, eferr);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_serial = bits[i];
      repeat (CPB) tick();
    end
    rx_serial = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic do_ack();
    inp_ack = 1'b1;
    tick();
    inp_ack = 1'b0;
    tick();
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
  endtask

  task automatic do_glitch();
    rx_serial = 1'b0;
    repeat (4) tick();
    rx_serial = 1'b1;
    repeat (30) tick();
  endtask

  task automatic apply_op(input op_e op, input logic [7:0] d, input logic stop, input int gap);
    case (op)
      OP_FRAME:  send_frame(d, stop, gap);
      OP_ACK:    do_ack();
      OP_CLR:    do_clr();
      OP_GLITCH: do_glitch();
      default:   tick();
    endcase
  endtask

  initial begin
    logic [9:0] bits;
    logic [7:0] m_head;
    logic [7:0] d;
    logic       stop;
    op_e        op;
    int         gap;
    int         r;

    rst       = 1'b1;
    rx_serial = 1'b1;
    inp_ack   = 1'b0;
    err_clr   = 1'b0;
    repeat (3) tick();
    check_state("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (5) tick();

    // Frame 0xA5: not visible early, visible by cycle 162 after the start edge.
    bits = {1'b1, 8'hA5, 1'b0};
    for (int t = 0; t < 170; t++) begin
      rx_serial = (t < 160) ? bits[t / CPB] : 1'b1;
      tick();
      if (t == 149) check_b("t1_fgi_early", FGI, 1'b0);
      if (t == 161) begin
        check_b("t1_fgi", FGI, 1'b1);
        check_v("t1_inpr", INPR, 8'hA5);
      end
    end
    inp_ack = 1'b1;
    tick();
    inp_ack = 1'b0;
    check_b("t1_fgi_after_ack", FGI, 1'b0);
    check_v("t1_inpr_after_ack", INPR, 8'h00);
    repeat (4) tick();

    // Overrun, ordered reads, empty ack, frame error, clears.
    tbl.push_back('{OP_FRAME, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0});
    tbl.push_back('{OP_FRAME, 8'h02, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0});
    tbl.push_back('{OP_FRAME, 8'h03, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0});
    tbl.push_back('{OP_FRAME, 8'h04, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0});
    tbl.push_back('{OP_FRAME, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0});
    tbl.push_back('{OP_ACK,   8'h00, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0});
    tbl.push_back('{OP_ACK,   8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0});
    tbl.push_back('{OP_ACK,   8'h00, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0});
    tbl.push_back('{OP_ACK,   8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{OP_ACK,   8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{OP_CLR,   8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{OP_FRAME, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{OP_CLR,   8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{OP_FRAME, 8'h42, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0});
    tbl.push_back('{OP_ACK,   8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{OP_GLITCH, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{OP_FRAME, 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0});
    tbl.push_back('{OP_ACK,   8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    foreach (tbl[i]) begin
      apply_op(tbl[i].op, tbl[i].data, tbl[i].stop, 20);
      check_state($sformatf("tbl%0d", i), tbl[i].exp_fgi, tbl[i].exp_inpr,
                  tbl[i].exp_ovr, tbl[i].exp_ferr);
    end

    // Full FIFO; a pop coincides with the stop sample of 0x77.
    send_frame(8'h11, 1'b1, 4);
    send_frame(8'h22, 1'b1, 4);
    send_frame(8'h33, 1'b1, 4);
    send_frame(8'h44, 1'b1, 4);
    check_state("t5_full", 1'b1, 8'h11, 1'b0, 1'b0);
    bits = {1'b1, 8'h77, 1'b0};
    for (int t = 0; t < 164; t++) begin
      rx_serial = (t < 160) ? bits[t / CPB] : 1'b1;
      inp_ack   = (t == 154);
      tick();
    end
    inp_ack = 1'b0;
    check_state("t5_coincide", 1'b1, 8'h22, 1'b0, 1'b0);
    do_ack();
    check_v("t5_rd33", INPR, 8'h33);
    do_ack();
    check_v("t5_rd44", INPR, 8'h44);
    do_ack();
    check_state("t5_rd77", 1'b1, 8'h77, 1'b0, 1'b0);
    do_ack();
    check_state("t5_empty", 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-DATA aborts the frame and clears everything.
    send_frame(8'h99, 1'b1, 4);
    send_frame(8'h3C, 1'b0, 20);
    check_state("t6_pre", 1'b1, 8'h99, 1'b0, 1'b1);
    rx_serial = 1'b0;
    repeat (60) tick();
    rst = 1'b1;
    repeat (2) tick();
    check_state("t6_in_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    rx_serial = 1'b1;
    rst = 1'b0;
    repeat (200) tick();
    check_state("t6_no_partial", 1'b0, 8'h00, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 4);
    check_state("t6_5a", 1'b1, 8'h5A, 1'b0, 1'b0);
    do_ack();
    check_state("t6_only_one", 1'b0, 8'h00, 1'b0, 1'b0);

    // Random operations against a queue model.
    mq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      stop = 1'b1;
      gap = 20;
      if (r <= 4) begin
        op = OP_FRAME;
        gap = $urandom_range(0, 3);
      end else if (r == 5) begin
        op = OP_FRAME;
        stop = 1'b0;
      end else if (r <= 7) begin
        op = OP_ACK;
      end else if (r == 8) begin
        op = OP_CLR;
      end else begin
        op = OP_GLITCH;
      end
      apply_op(op, d, stop, gap);
      case (op)
        OP_FRAME: begin
          if (!stop) m_ferr = 1'b1;
          else if (mq.size() < DEPTH) mq.push_back(d);
          else m_ovr = 1'b1;
        end
        OP_ACK: if (mq.size() > 0) void'(mq.pop_front());
        OP_CLR: begin
          m_ovr  = 1'b0;
          m_ferr = 1'b0;
        end
        default: ;
      endcase
      m_head = (mq.size() > 0) ? mq[0] : 8'h00;
      check_state($sformatf("rnd%0d", i), (mq.size() > 0), m_head, m_ovr, m_ferr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
